// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter slice: counter width and the
// debounce state encoding used by the direction-control stage.
package counter_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << CNT_W) - 1);

    typedef logic [1:0] db_state_t;

    localparam db_state_t DB_IDLE         = 2'b00;
    localparam db_state_t DB_PRESS_WAIT   = 2'b01;
    localparam db_state_t DB_PRESSED      = 2'b10;
    localparam db_state_t DB_RELEASE_WAIT = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus a four-state debounce FSM; emits the accepted
// button level and a single-cycle press pulse on each accepted assertion.
module btn_debounce
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic btn_db,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LIMIT = CW'(DEBOUNCE_CYCLES);

    logic            r_sync0;
    logic            r_sync1;
    db_state_t       r_state;
    db_state_t       w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [CW-1:0]   w_cnt_inc;
    logic            r_btn_db;
    logic            w_btn_db_next;
    logic            r_press;
    logic            w_press_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_state  <= DB_IDLE;
            r_cnt    <= '0;
            r_btn_db <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_sync0  <= btn;
            r_sync1  <= r_sync0;
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_btn_db <= w_btn_db_next;
            r_press  <= w_press_next;
        end
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_btn_db_next = r_btn_db;
        w_press_next  = 1'b0;
        case (r_state)
            DB_IDLE: begin
                if (r_sync1) begin
                    w_state_next = DB_PRESS_WAIT;
                    w_cnt_next   = CW'(1);
                end
            end
            DB_PRESS_WAIT: begin
                if (!r_sync1) begin
                    w_state_next = DB_IDLE;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc == DB_LIMIT) begin
                    w_state_next  = DB_PRESSED;
                    w_cnt_next    = '0;
                    w_btn_db_next = 1'b1;
                    w_press_next  = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            DB_PRESSED: begin
                if (!r_sync1) begin
                    w_state_next = DB_RELEASE_WAIT;
                    w_cnt_next   = CW'(1);
                end
            end
            default: begin
                // Release side mirrors the press side but never pulses press.
                if (r_sync1) begin
                    w_state_next = DB_PRESSED;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc == DB_LIMIT) begin
                    w_state_next  = DB_IDLE;
                    w_cnt_next    = '0;
                    w_btn_db_next = 1'b0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
        endcase
    end

    assign btn_db = r_btn_db;
    assign press  = r_press;

endmodule

// File: rtl/updown_dir_ctrl.sv
// Direction control for the up/down counter: button presses toggle the
// direction and, in auto mode, the fed-back count reverses it at the limits.
module updown_dir_ctrl
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = counter_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn,
    input  logic             mode,
    input  logic [CNT_W-1:0] cnt,
    output logic             up,
    output logic             dir_change,
    output logic             btn_db
);

    // Reverse one count early: the counter samples up on the same edge.
    localparam logic [CNT_W-1:0] LIM_HI = CNT_W'((1 << CNT_W) - 2);
    localparam logic [CNT_W-1:0] LIM_LO = CNT_W'(1);

    logic w_press;
    logic w_btn_db;
    logic r_up;
    logic w_up_next;
    logic r_dir_change;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .btn    (btn),
        .btn_db (w_btn_db),
        .press  (w_press)
    );

    always_comb begin
        w_up_next = r_up;
        if (mode && r_up && (cnt == LIM_HI)) begin
            w_up_next = 1'b0;
        end else if (mode && !r_up && (cnt == LIM_LO)) begin
            w_up_next = 1'b1;
        end else if (w_press) begin
            w_up_next = ~r_up;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_up         <= 1'b1;
            r_dir_change <= 1'b0;
        end else begin
            r_up         <= w_up_next;
            r_dir_change <= (w_up_next != r_up);
        end
    end

    assign up         = r_up;
    assign dir_change = r_dir_change;
    assign btn_db     = w_btn_db;

endmodule

// File: doc/updown_dir_ctrl.md
Name: updown_dir_ctrl

Overview:
- Direction-control stage that sits directly upstream of the 4-bit up/down counter FSM and drives its `up` input.
- Synchronizes and debounces a raw push-button; each debounced press toggles the count direction.
- In auto mode, it also reads the counter's `cnt` back and reverses direction at the range limits, giving a ping-pong count 0..15..0 with no wrap.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronized samples a button level must hold before it is accepted (>=2).
- CNT_W, 4, width of the counter value fed back from the counter.

Ports:
- clock  input  1  system clock; all flops on rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn  input  1  raw push-button, active-high, asynchronous to clock, may bounce.
- mode  input  1  0 = manual (button toggles only); 1 = auto ping-pong (limits reverse, button also toggles).
- cnt  input  CNT_W  current count fed back from the downstream counter.
- up  output  1  count direction to the counter; 1 = up, 0 = down; registered.
- dir_change  output  1  one-cycle pulse, high in the same cycle `up` takes a new value; registered.
- btn_db  output  1  debounced button level; registered.

Behaviour:
- Reset (async assert, sync-free deassert handled by flops): `up`=1, `dir_change`=0, `btn_db`=0, sync flops=0, debounce FSM=IDLE, debounce counter=0. Reset asserted mid-debounce or mid-count aborts immediately; no press is generated.
- Synchronizer: 2 flops; btn_s = second flop.
- Debounce FSM, 4 states:
  - IDLE (btn_db=0): btn_s=1 -> PRESS_WAIT, counter=1.
  - PRESS_WAIT: btn_s=1 increments the counter; when the counter reaches DEBOUNCE_CYCLES -> PRESSED, btn_db<=1, one-cycle internal `press`. btn_s=0 -> IDLE, counter=0.
  - PRESSED (btn_db=1): btn_s=0 -> RELEASE_WAIT, counter=1.
  - RELEASE_WAIT: btn_s=0 increments the counter; when it reaches DEBOUNCE_CYCLES -> IDLE, btn_db<=0. btn_s=1 -> PRESSED, counter=0.
  - Release generates no press.
- Latency: with raw btn stable high before edge 0, btn_s is high after edge 1, btn_db rises after edge 1+DEBOUNCE_CYCLES, and `up` toggles after edge 2+DEBOUNCE_CYCLES.
- Direction register, evaluated each edge, in priority order:
  1. mode=1, up=1, cnt==2^CNT_W-2: up<=0.
  2. mode=1, up=0, cnt==1: up<=1.
  3. Otherwise, `press`: up<=~up.
- Limit detection anticipates by one count because the counter samples `up` on the same edge. With mode=1 the count sequence is ...13,14,15,14,13... and ...2,1,0,1,2...; 15->0 and 0->15 never occur.
- A press in the same cycle as a limit reversal is dropped; the limit value wins and `dir_change` pulses once.
- `dir_change` is 1 exactly in the cycles where `up` differs from its previous value.
- Mode change takes effect at the next edge. If mode is set to 1 while cnt is already 15 with up=1, or 0 with up=0, one wrap occurs, then ping-pong proceeds normally. The limit checks use cnt==14/1, not 15/0.
- btn held indefinitely: exactly one press per debounced assertion.

Decomposition:
- Shared package counter_pkg:
  - CNT_W and CNT_MAX (2^CNT_W-1).
  - Debounce state encoding as 2-bit localparams: IDLE=00, PRESS_WAIT=01, PRESSED=10, RELEASE_WAIT=11.
- Sub-module btn_debounce (synchronizer + debounce FSM + counter; outputs btn_db and press).
- Top holds the direction register, limit logic and dir_change.

Test Plan (DEBOUNCE_CYCLES=4, counter instantiated downstream, cnt fed back):
- Reset release, btn=0, mode=0 -> up=1, dir_change=0, btn_db=0; counter counts 0,1,2,...,15,0 (wrap allowed in manual mode).
- mode=0, btn high from edge 0 held 20 cycles -> btn_db=1 after edge 5; up=0 and dir_change=1 after edge 6 only; counter then decrements.
- mode=0, btn bouncing 1,1,1,0,1,1,0 (max 3 consecutive highs) -> btn_db stays 0, up unchanged, dir_change never asserted.
- mode=1 from reset -> cnt sequence 0..14,15,14,...,1,0,1,...; dir_change pulses at the edges where cnt becomes 15 and 0; cnt never wraps over two full periods.
- mode=1, debounced press landing on the edge where cnt becomes 15 -> up=0, single dir_change pulse, next cnt=14.
- reset asserted while FSM is in PRESS_WAIT with counter=3 -> outputs return to reset values immediately; after release with btn still high, a full 4-sample debounce is required before btn_db rises.
